// File: rtl/sort_pkg.sv
// Shared types and key-ordering helper for the sorting tree.
// Key comparisons are unsigned; ties always favour input A so merges stay stable.
package sort_pkg;

  localparam int SORT_WIDTH = 32;
  // Widest key supported by the shared ordering helper.
  localparam int KEY_MAX_W = 64;

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } merge_state_t;

  // Returns 1 when key a must leave before key b (equal keys -> a).
  function automatic logic key_first(input logic [KEY_MAX_W-1:0] a,
                                     input logic [KEY_MAX_W-1:0] b,
                                     input logic                 descend);
    return descend ? (a >= b) : (a <= b);
  endfunction

endpackage

// File: rtl/sort_cmp.sv
// Key comparator shared by all merge stages of the sorting tree.
// a_first=1 selects key a; equal keys select a.
module sort_cmp
  import sort_pkg::*;
#(
  parameter int WIDTH   = SORT_WIDTH,
  parameter int DESCEND = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_first
);

  logic [KEY_MAX_W-1:0] a_ext;
  logic [KEY_MAX_W-1:0] b_ext;

  // Zero extension keeps the unsigned ordering of the original keys.
  assign a_ext   = KEY_MAX_W'(a);
  assign b_ext   = KEY_MAX_W'(b);
  assign a_first = key_first(a_ext, b_ext, (DESCEND != 0));

endmodule

// File: rtl/merge_node.sv
// Two-way merge node: pops one RUN_LEN run from each upstream FIFO and pushes
// a single sorted 2*RUN_LEN run downstream, one key per cycle, zero latency.
module merge_node
  import sort_pkg::*;
#(
  parameter int WIDTH   = SORT_WIDTH,
  parameter int RUN_LEN = 4,
  parameter int DESCEND = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_dout,
  input  logic             a_empty,
  output logic             a_deq,
  input  logic [WIDTH-1:0] b_dout,
  input  logic             b_empty,
  output logic             b_deq,
  output logic [WIDTH-1:0] o_din,
  output logic             o_enq,
  input  logic             o_full,
  output logic             run_done
);

  localparam int CW = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(RUN_LEN - 1);

  merge_state_t  state_reg, state_next;
  logic [CW-1:0] cnt_a_reg, cnt_a_next;
  logic [CW-1:0] cnt_b_reg, cnt_b_next;
  logic          done_reg, done_next;

  logic a_first;
  logic take_a;
  logic take_b;

  sort_cmp #(
    .WIDTH  (WIDTH),
    .DESCEND(DESCEND)
  ) u_cmp (
    .a      (a_dout),
    .b      (b_dout),
    .a_first(a_first)
  );

  // In the drain states the exhausted side's empty flag and head key are
  // ignored, so the next run of that input is never read ahead.
  always_comb begin
    take_a = 1'b0;
    take_b = 1'b0;
    case (state_reg)
      MERGE: begin
        if (!a_empty && !b_empty && !o_full) begin
          if (a_first) take_a = 1'b1;
          else         take_b = 1'b1;
        end
      end
      DRAIN_A: if (!a_empty && !o_full) take_a = 1'b1;
      DRAIN_B: if (!b_empty && !o_full) take_b = 1'b1;
      default: ;
    endcase
    if (rst) begin
      take_a = 1'b0;
      take_b = 1'b0;
    end
  end

  assign a_deq    = take_a;
  assign b_deq    = take_b;
  assign o_enq    = take_a | take_b;
  assign o_din    = take_b ? b_dout : a_dout;
  assign run_done = done_reg;

  always_comb begin
    state_next = state_reg;
    cnt_a_next = cnt_a_reg;
    cnt_b_next = cnt_b_reg;
    done_next  = 1'b0;
    if (take_a) cnt_a_next = cnt_a_reg + CW'(1);
    if (take_b) cnt_b_next = cnt_b_reg + CW'(1);
    case (state_reg)
      MERGE: begin
        if (take_a && cnt_a_reg == LAST) state_next = DRAIN_B;
        if (take_b && cnt_b_reg == LAST) state_next = DRAIN_A;
      end
      DRAIN_A: begin
        if (take_a && cnt_a_reg == LAST) begin
          state_next = MERGE;
          cnt_a_next = '0;
          cnt_b_next = '0;
          done_next  = 1'b1;
        end
      end
      DRAIN_B: begin
        if (take_b && cnt_b_reg == LAST) begin
          state_next = MERGE;
          cnt_a_next = '0;
          cnt_b_next = '0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = MERGE;
        cnt_a_next = '0;
        cnt_b_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MERGE;
      cnt_a_reg <= '0;
      cnt_b_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_a_reg <= cnt_a_next;
      cnt_b_reg <= cnt_b_next;
      done_reg  <= done_next;
    end
  end

endmodule

// File: tb/tb_merge_node.sv
// Directed bench for merge_node: per-vector select table plus multi-cycle
// run sequences driven from queue-modelled upstream FIFOs.
module tb_merge_node;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] a_dout, b_dout, o_din;
  logic        a_empty, b_empty, a_deq, b_deq, o_enq, o_full, run_done;

  logic [31:0] d_a_dout, d_b_dout, d_o_din;
  logic        d_a_empty, d_b_empty, d_a_deq, d_b_deq, d_o_enq, d_o_full, d_run_done;

  merge_node #(.WIDTH(32), .RUN_LEN(4), .DESCEND(0)) dut (
    .clk(clk), .rst(rst),
    .a_dout(a_dout), .a_empty(a_empty), .a_deq(a_deq),
    .b_dout(b_dout), .b_empty(b_empty), .b_deq(b_deq),
    .o_din(o_din), .o_enq(o_enq), .o_full(o_full), .run_done(run_done)
  );

  merge_node #(.WIDTH(32), .RUN_LEN(4), .DESCEND(1)) dut_d (
    .clk(clk), .rst(rst),
    .a_dout(d_a_dout), .a_empty(d_a_empty), .a_deq(d_a_deq),
    .b_dout(d_b_dout), .b_empty(d_b_empty), .b_deq(d_b_deq),
    .o_din(d_o_din), .o_enq(d_o_enq), .o_full(d_o_full), .run_done(d_run_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  logic        log_ad[$], log_bd[$], log_en[$], log_done[$];
  logic [31:0] log_din[$];
  logic        e_ad[$], e_bd[$], e_done[$];
  logic [31:0] e_din[$];

  typedef struct {
    logic [31:0] a;
    logic        ae;
    logic [31:0] b;
    logic        be;
    logic        full;
    logic        x_ad;
    logic        x_bd;
    logic [31:0] x_din;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_dout = 0; b_dout = 0; a_empty = 1; b_empty = 1; o_full = 0;
    d_a_dout = 0; d_b_dout = 0; d_a_empty = 1; d_b_empty = 1; d_o_full = 0;
  endtask

  // Called at a negedge; returns at a negedge with rst released.
  task automatic do_reset();
    rst = 1'b1;
    qa.delete();
    qb.delete();
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic exp_cycle(input logic ad, input logic bd, input logic [31:0] din, input logic done);
    e_ad.push_back(ad);
    e_bd.push_back(bd);
    e_din.push_back(din);
    e_done.push_back(done);
  endtask

  // Runs n cycles from a negedge; bit i of full_mask drives o_full in cycle i.
  task automatic run(input bit desc, input int n, input logic [63:0] full_mask);
    logic s_ad, s_bd, s_en, s_done;
    logic [31:0] s_din;
    log_ad.delete(); log_bd.delete(); log_en.delete(); log_done.delete(); log_din.delete();
    for (int i = 0; i < n; i++) begin
      if (!desc) begin
        a_empty = (qa.size() == 0); a_dout = a_empty ? 32'd0 : qa[0];
        b_empty = (qb.size() == 0); b_dout = b_empty ? 32'd0 : qb[0];
        o_full  = full_mask[i];
      end else begin
        d_a_empty = (qa.size() == 0); d_a_dout = d_a_empty ? 32'd0 : qa[0];
        d_b_empty = (qb.size() == 0); d_b_dout = d_b_empty ? 32'd0 : qb[0];
        d_o_full  = full_mask[i];
      end
      #1;
      if (!desc) begin
        s_ad = a_deq; s_bd = b_deq; s_en = o_enq; s_din = o_din; s_done = run_done;
      end else begin
        s_ad = d_a_deq; s_bd = d_b_deq; s_en = d_o_enq; s_din = d_o_din; s_done = d_run_done;
      end
      log_ad.push_back(s_ad); log_bd.push_back(s_bd); log_en.push_back(s_en);
      log_din.push_back(s_din); log_done.push_back(s_done);
      @(posedge clk);
      if (s_ad && qa.size() > 0) void'(qa.pop_front());
      if (s_bd && qb.size() > 0) void'(qb.pop_front());
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic check_logs(input string tname);
    if (log_ad.size() != e_ad.size()) begin
      chk({tname, " length"}, log_ad.size(), e_ad.size());
    end else begin
      for (int i = 0; i < e_ad.size(); i++) begin
        $display("[%s c%0d] a_deq=%0b b_deq=%0b o_enq=%0b o_din=%0d run_done=%0b",
                 tname, i, log_ad[i], log_bd[i], log_en[i], log_din[i], log_done[i]);
        chk($sformatf("%s c%0d a_deq", tname, i), 32'(log_ad[i]), 32'(e_ad[i]));
        chk($sformatf("%s c%0d b_deq", tname, i), 32'(log_bd[i]), 32'(e_bd[i]));
        chk($sformatf("%s c%0d o_enq", tname, i), 32'(log_en[i]), 32'(e_ad[i] | e_bd[i]));
        if (e_ad[i] | e_bd[i])
          chk($sformatf("%s c%0d o_din", tname, i), log_din[i], e_din[i]);
        chk($sformatf("%s c%0d run_done", tname, i), 32'(log_done[i]), 32'(e_done[i]));
      end
    end
    e_ad.delete(); e_bd.delete(); e_din.delete(); e_done.delete();
  endtask

  task automatic load_t1();
    qa = '{32'd1, 32'd3, 32'd5, 32'd7};
    qb = '{32'd2, 32'd4, 32'd6, 32'd8};
  endtask

  task automatic exp_t1();
    for (int i = 0; i < 8; i++) exp_cycle((i % 2) == 0, (i % 2) == 1, 32'(i + 1), 1'b0);
    exp_cycle(0, 0, 0, 1);
    exp_cycle(0, 0, 0, 0);
  endtask

  initial begin
    idle_inputs();
    // a, a_empty, b, b_empty, o_full -> a_deq, b_deq, o_din (MERGE, counters 0)
    vecs[0] = '{32'd3, 0, 32'd5, 0, 0, 1, 0, 32'd3};
    vecs[1] = '{32'd9, 0, 32'd2, 0, 0, 0, 1, 32'd2};
    vecs[2] = '{32'd4, 0, 32'd4, 0, 0, 1, 0, 32'd4};
    vecs[3] = '{32'd0, 1, 32'd2, 0, 0, 0, 0, 32'd0};
    vecs[4] = '{32'd7, 0, 32'd0, 1, 0, 0, 0, 32'd7};
    vecs[5] = '{32'd1, 0, 32'd2, 0, 1, 0, 0, 32'd1};
    vecs[6] = '{32'hFFFF_FFFF, 0, 32'd1, 0, 0, 0, 1, 32'd1};
    vecs[7] = '{32'h8000_0000, 0, 32'h7FFF_FFFF, 0, 0, 0, 1, 32'h7FFF_FFFF};

    @(negedge clk);
    do_reset();
    // Reset state: no strobes, no run_done
    #1;
    chk("reset run_done", 32'(run_done), 32'd0);
    chk("reset o_enq", 32'(o_enq), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      a_dout = vecs[i].a; a_empty = vecs[i].ae;
      b_dout = vecs[i].b; b_empty = vecs[i].be; o_full = vecs[i].full;
      #1;
      $display("[vec %0d] a=%0d/%0b b=%0d/%0b full=%0b -> a_deq=%0b b_deq=%0b o_enq=%0b o_din=%0d",
               i, a_dout, a_empty, b_dout, b_empty, o_full, a_deq, b_deq, o_enq, o_din);
      chk($sformatf("vec%0d a_deq", i), 32'(a_deq), 32'(vecs[i].x_ad));
      chk($sformatf("vec%0d b_deq", i), 32'(b_deq), 32'(vecs[i].x_bd));
      chk($sformatf("vec%0d o_enq", i), 32'(o_enq), 32'(vecs[i].x_ad | vecs[i].x_bd));
      chk($sformatf("vec%0d o_din", i), o_din, vecs[i].x_din);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
    end

    // Test 1: basic interleaved merge
    do_reset();
    load_t1();
    run(0, 10, 64'd0);
    exp_t1();
    check_logs("t1");

    // Test 2: all ties; next A run (smaller keys) waits until B run is drained
    do_reset();
    qa = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0};
    qb = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd9, 32'd9, 32'd9, 32'd9};
    run(0, 17, 64'd0);
    for (int i = 0; i < 4; i++) exp_cycle(1, 0, 32'd5, 0);
    for (int i = 0; i < 4; i++) exp_cycle(0, 1, 32'd5, 0);
    exp_cycle(1, 0, 32'd0, 1);
    for (int i = 0; i < 3; i++) exp_cycle(1, 0, 32'd0, 0);
    for (int i = 0; i < 4; i++) exp_cycle(0, 1, 32'd9, 0);
    exp_cycle(0, 0, 0, 1);
    check_logs("t2");

    // Test 3: backpressure for 3 cycles after the 3rd output
    do_reset();
    load_t1();
    run(0, 12, 64'b111000);
    exp_cycle(1, 0, 32'd1, 0);
    exp_cycle(0, 1, 32'd2, 0);
    exp_cycle(1, 0, 32'd3, 0);
    for (int i = 0; i < 3; i++) exp_cycle(0, 0, 0, 0);
    exp_cycle(0, 1, 32'd4, 0);
    exp_cycle(1, 0, 32'd5, 0);
    exp_cycle(0, 1, 32'd6, 0);
    exp_cycle(1, 0, 32'd7, 0);
    exp_cycle(0, 1, 32'd8, 0);
    exp_cycle(0, 0, 0, 1);
    check_logs("t3");

    // Test 4: A empty in MERGE stalls; in DRAIN_B A's empty flag is ignored
    do_reset();
    qb = '{32'd2};
    run(0, 2, 64'd0);
    exp_cycle(0, 0, 0, 0);
    exp_cycle(0, 0, 0, 0);
    check_logs("t4a");
    qa = '{32'd0, 32'd0, 32'd1, 32'd1};
    run(0, 6, 64'd0);
    exp_cycle(1, 0, 32'd0, 0);
    exp_cycle(1, 0, 32'd0, 0);
    exp_cycle(1, 0, 32'd1, 0);
    exp_cycle(1, 0, 32'd1, 0);
    exp_cycle(0, 1, 32'd2, 0);
    exp_cycle(0, 0, 0, 0);
    check_logs("t4b");

    // Test 5: reset mid-run discards progress
    do_reset();
    load_t1();
    run(0, 3, 64'd0);
    exp_cycle(1, 0, 32'd1, 0);
    exp_cycle(0, 1, 32'd2, 0);
    exp_cycle(1, 0, 32'd3, 0);
    check_logs("t5pre");
    a_dout = 32'd5; a_empty = 0; b_dout = 32'd4; b_empty = 0; o_full = 0;
    rst = 1'b1;
    #1;
    chk("t5 rst a_deq", 32'(a_deq), 32'd0);
    chk("t5 rst b_deq", 32'(b_deq), 32'd0);
    chk("t5 rst o_enq", 32'(o_enq), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("t5 post run_done", 32'(run_done), 32'd0);
    chk("t5 post o_enq", 32'(o_enq), 32'd0);
    @(negedge clk);
    qa.delete();
    qb.delete();
    load_t1();
    run(0, 10, 64'd0);
    exp_t1();
    check_logs("t5run");

    // Test 6: back-to-back runs, no bubble
    do_reset();
    qa = '{32'd1, 32'd4, 32'd6, 32'd9, 32'd0, 32'd2, 32'd2, 32'd3};
    qb = '{32'd3, 32'd5, 32'd7, 32'd8, 32'd1, 32'd1, 32'd9, 32'd9};
    run(0, 18, 64'd0);
    exp_cycle(1, 0, 32'd1, 0); exp_cycle(0, 1, 32'd3, 0);
    exp_cycle(1, 0, 32'd4, 0); exp_cycle(0, 1, 32'd5, 0);
    exp_cycle(1, 0, 32'd6, 0); exp_cycle(0, 1, 32'd7, 0);
    exp_cycle(0, 1, 32'd8, 0); exp_cycle(1, 0, 32'd9, 0);
    exp_cycle(1, 0, 32'd0, 1); exp_cycle(0, 1, 32'd1, 0);
    exp_cycle(0, 1, 32'd1, 0); exp_cycle(1, 0, 32'd2, 0);
    exp_cycle(1, 0, 32'd2, 0); exp_cycle(1, 0, 32'd3, 0);
    exp_cycle(0, 1, 32'd9, 0); exp_cycle(0, 1, 32'd9, 0);
    exp_cycle(0, 0, 0, 1);     exp_cycle(0, 0, 0, 0);
    check_logs("t6");

    // Descending node: 8..1
    do_reset();
    qa = '{32'd7, 32'd5, 32'd3, 32'd1};
    qb = '{32'd8, 32'd6, 32'd4, 32'd2};
    run(1, 10, 64'd0);
    for (int i = 0; i < 8; i++) exp_cycle((i % 2) == 1, (i % 2) == 0, 32'(8 - i), 1'b0);
    exp_cycle(0, 0, 0, 1);
    exp_cycle(0, 0, 0, 0);
    check_logs("tdesc");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
